// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache: 8 lines of 16 bytes between the fetch stage and block memory.
// Hits complete in the same cycle; misses stall through MEM_READ and UPDATE while a block is filled.
module icache_direct_mapped (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic [9:0]   address,
  output logic [31:0]  instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [5:0]   mem_address,
  input  logic [127:0] mem_readinst,
  input  logic         mem_busywait
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  state_t state, next_state;

  logic [127:0] data_mem [8];
  logic [2:0]   tag_mem  [8];
  logic [7:0]   valid;

  logic [2:0] addr_tag;
  logic [2:0] addr_idx;
  logic [1:0] addr_off;
  logic       hit;
  logic       fill;
  logic       unused_byte_bits;

  assign addr_tag         = address[9:7];
  assign addr_idx         = address[6:4];
  assign addr_off         = address[3:2];
  assign unused_byte_bits = ^address[1:0];

  assign hit = valid[addr_idx] && (tag_mem[addr_idx] == addr_tag);

  always_comb begin
    instruction = 32'h0;
    if (hit) begin
      case (addr_off)
        2'd0:    instruction = data_mem[addr_idx][31:0];
        2'd1:    instruction = data_mem[addr_idx][63:32];
        2'd2:    instruction = data_mem[addr_idx][95:64];
        default: instruction = data_mem[addr_idx][127:96];
      endcase
    end
  end

  always_comb begin
    next_state = state;
    busywait   = 1'b0;
    mem_read   = 1'b0;
    fill       = 1'b0;
    case (state)
      IDLE: begin
        if (read && !hit) begin
          busywait   = 1'b1;
          next_state = MEM_READ;
        end
      end
      MEM_READ: begin
        busywait = 1'b1;
        mem_read = 1'b1;
        if (!mem_busywait) begin
          next_state = UPDATE;
        end
      end
      UPDATE: begin
        busywait   = 1'b1;
        fill       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      valid       <= 8'h00;
      mem_address <= 6'h00;
    end else begin
      state <= next_state;
      if (state == IDLE && read && !hit) begin
        mem_address <= address[9:4];
      end
      if (fill) begin
        valid[mem_address[2:0]] <= 1'b1;
      end
    end
  end

  // The latched block address carries both the fill tag and the fill index.
  always_ff @(posedge clock) begin
    if (fill) begin
      data_mem[mem_address[2:0]] <= mem_readinst;
      tag_mem[mem_address[2:0]]  <= mem_address[5:3];
    end
  end

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped instruction cache between the CPU fetch stage (10-bit PC byte address, 32-bit instruction) and the 16-byte-block instruction memory (6-bit block address, 128-bit block, read/busywait handshake).
- Hits return the instruction in the same cycle with no stall.
- Misses stall the CPU via busywait, fetch the whole block from instruction memory, install it, then complete the fetch.

Parameters:
- None. Geometry is fixed: 8 lines x 16 bytes (128 B total).
- Address split: tag = address[9:7] (3b), index = address[6:4] (3b), word offset = address[3:2] (2b).
- address[1:0] is ignored.

Ports:
- clock  input  1  system clock, all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- read  input  1  CPU fetch request; held high while fetching.
- address  input  10  CPU PC byte address.
- instruction  output  32  fetched instruction word.
- busywait  output  1  stall to CPU.
- mem_read  output  1  read request to instruction memory.
- mem_address  output  6  block address to instruction memory.
- mem_readinst  input  128  block data from instruction memory; byte 0 in [7:0].
- mem_busywait  input  1  instruction memory busy.

Behaviour:
- Storage, per line:
  - data[127:0], not reset.
  - tag[2:0], not reset.
  - valid, cleared by reset.
- hit (combinational) = valid[index] && tag[index] == address[9:7].
- instruction (combinational):
  - When hit, it is data[index] word at offset, i.e. bits [32*off+31 : 32*off]. Word 0 is the low 32 bits.
  - Otherwise it is 32'h0.
- State machine: IDLE, MEM_READ, UPDATE. Reset (async, reset==0) forces:
  - state = IDLE, all valid = 0, mem_read = 0, mem_address = 0.
- IDLE:
  - busywait = read && !hit (combinational). mem_read = 0.
  - If read && !hit at posedge: latch mem_address <= address[9:4] and latched tag/index, then go to MEM_READ.
  - If read is low, or on a hit: stay in IDLE. No memory traffic.
- MEM_READ:
  - busywait = 1, mem_read = 1, and mem_address holds the latched value.
  - At each posedge, if mem_busywait == 0, go to UPDATE; otherwise stay.
  - mem_busywait is never sampled in the entry cycle. Instruction memory raises it combinationally from mem_read, so it is already 1 at the first posedge.
- UPDATE:
  - busywait = 1, mem_read = 0.
  - At posedge: data[idx] <= mem_readinst, tag[idx] <= latched tag, valid[idx] <= 1, then go to IDLE.
- The next IDLE cycle sees a hit, so busywait falls with the correct instruction. Miss penalty is 2 cycles plus memory latency.
- Memory gets exactly one request per miss: mem_read is high only in MEM_READ.
- If address changes during MEM_READ/UPDATE (CPU misbehaving), the latched request still completes. The new address is evaluated afresh in IDLE.
- Replacement: the miss unconditionally overwrites the indexed line. Instruction cache lines are never dirty, so there is no writeback.
- Reset mid-fill:
  - mem_read drops immediately and no line is written.
  - After release, the next read is a cold miss.
- read low in IDLE: busywait = 0 and no state change, regardless of address.

Test Plan:
- Cold miss: reset, read=1, address=0 → busywait=1, mem_read=1, mem_address=0. After mem_busywait falls, one UPDATE cycle, then busywait=0 and instruction=mem_readinst[31:0] (e.g. 32'h0004_0019).
- Same-block hits: addresses 4, 8, 12 after the fill → busywait stays 0 every cycle, instruction equals words 1..3 of the block, no mem_read pulse.
- Conflict eviction: address 128 (tag 1, index 0) → miss with mem_address=8, line 0 replaced. Then address 0 → miss again with mem_address=0.
- Different index: address 16 → miss with mem_address=1, line 1 filled; line 0 contents still hit afterwards.
- Reset in MEM_READ: assert reset while mem_read=1 → mem_read=0 and busywait follows IDLE rule immediately. Re-fetch of address 0 after release misses.
- Idle: read=0 with arbitrary addresses for 10 cycles → busywait=0, mem_read=0 throughout.
